trail_writer: RTL and testbench
===============================

// Module: trail_writer
// PURPOSE
//  Upstream write stage of the double-pixel frame buffer.
//  - Each frame, paints both bikes' current positions into frameRAM as trail pixels.
//  - Drives write_address/Data_In/WE of the frame buffer.
//  - On reset or request, clears the whole buffer to background.
//  - Word format: one 16-bit word = two horizontal pixels, {8'h00, even_px[7:4], odd_px[3:0]}.
//  - Trails are written per pixel pair (both nibbles same color); no read-modify-write.
// PARAMETERS
//  H_PIX     640    visible width; word row pitch = H_PIX/2
//  V_PIX     480    visible height
//  ADDR_W    19     write address width
//  BG_COLOR  4'h0   color enum used by clear
//  P1_COLOR  4'h1   bike 1 trail color enum
//  P2_COLOR  4'h2   bike 2 trail color enum
// PORTS
//  Clk            in   1       system clock
//  Reset          in   1       asynchronous, active-low reset
//  frame_clk      in   1       frame strobe (~60 Hz), async to Clk
//  clear_req      in   1       level/pulse: request full-buffer clear
//  p1_x, p1_y     in   10 ea   bike 1 pixel position
//  p1_alive       in   1       bike 1 writes trail when 1
//  p2_x, p2_y     in   10 ea   bike 2 pixel position
//  p2_alive       in   1       bike 2 writes trail when 1
//  write_address  out  ADDR_W  frameRAM word address
//  Data_In        out  16      frameRAM write data
//  WE             out  1       frameRAM write enable, one Clk per word
//  busy           out  1       1 in any state but IDLE
//  clear_done     out  1       1-Clk pulse when a clear finishes
// BEHAVIOUR
//  - Reset (Reset=0, async): WE=0, write_address=0, Data_In=0, clear_done=0, busy=1, state=CLEAR, clr_cnt=0.
//  - All outputs registered.
//  - frame_clk: 2-flop synchronised; a rising edge yields a 1-Clk frame_tick.
//  - Address = x[9:1] + y*(H_PIX/2), computed as (y<<8)+(y<<6) for 640.
//  - States:
//    - CLEAR: each Clk emits WE=1, write_address=clr_cnt, Data_In={8'h00,BG,BG}; clr_cnt++.
//      After address H_PIX/2*V_PIX-1 (153599): clear_done=1 for 1 Clk, go to IDLE.
//      frame_tick and clear_req are dropped while in CLEAR.
//    - IDLE: pending clear -> CLEAR (clr_cnt=0); else frame_tick -> snapshot all p* inputs, go to W_P1.
//      Clear has priority over a same-cycle frame_tick.
//    - W_P1: if p1_alive and on-screen (x<H_PIX, y<V_PIX): one write, Data_In={8'h00,P1,P1}; else WE=0. Next: W_P2.
//    - W_P2: same for bike 2 with P2_COLOR. Next: IDLE.
//  - clear_req outside CLEAR sets a pending flag, serviced on the next IDLE.
//  - Frame writes use the snapshot; input changes mid-sequence are ignored.
//  - WE=0 in IDLE; Data_In/write_address hold their last value.
//  - Reset mid-operation aborts immediately; clear restarts from address 0.
//  - frame_tick arriving during W_P1/W_P2 is dropped.
// CONFIGURATION
//  TRAIL_DOUBLE_EN
//   - Defined: each bike paints a 2x2 block. W_P1/W_P2 each issue a second write at row y+1
//     (same word column, address +H_PIX/2) on the next Clk. The second write is suppressed if y+1>=V_PIX.
//   - Undefined: one word per bike per frame; no extra states.
// TESTING
//  1. Release Reset -> 153600 consecutive WE=1 Clks, addr 0..153599, Data_In=16'h0000;
//     clear_done pulses once; busy falls the next Clk.
//  2. p1=(101,50) alive, p2=(640,10) alive, frame edge -> exactly one write:
//     addr 16050, Data_In=16'h0011 (p2 off-screen, suppressed).
//  3. p1_alive=0, p2=(0,479) alive, frame edge -> one write: addr 153280, Data_In=16'h0022.
//  4. clear_req pulse during W_P1 -> W_P1 and W_P2 writes complete, then full clear;
//     frame edges during the clear produce no writes.
//  5. Reset low at clr_cnt=1000 -> WE=0 asynchronously; after release, clear restarts at addr 0.
//  6. TRAIL_DOUBLE_EN, p1=(10,20), p2 dead -> writes at addr 6405 then 6725, both 16'h0011.
//     p1=(10,479) -> only 153285.

Source files
------------

// File: rtl/trail_writer.sv
// trail_writer: paints both bikes into the double-pixel frame buffer each frame and
// clears the buffer to background on reset/request. Define TRAIL_DOUBLE_EN for 2x2 trail blocks.
module trail_writer #(
    parameter int         H_PIX    = 640,
    parameter int         V_PIX    = 480,
    parameter int         ADDR_W   = 19,
    parameter logic [3:0] BG_COLOR = 4'h0,
    parameter logic [3:0] P1_COLOR = 4'h1,
    parameter logic [3:0] P2_COLOR = 4'h2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              clear_req,
    input  logic [9:0]        p1_x,
    input  logic [9:0]        p1_y,
    input  logic              p1_alive,
    input  logic [9:0]        p2_x,
    input  logic [9:0]        p2_y,
    input  logic              p2_alive,
    output logic [ADDR_W-1:0] write_address,
    output logic [15:0]       Data_In,
    output logic              WE,
    output logic              busy,
    output logic              clear_done
);
    localparam int                ROW_W     = H_PIX / 2;
    localparam logic [ADDR_W-1:0] ROW_PITCH = ADDR_W'(ROW_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ROW_W * V_PIX - 1);
    localparam logic [10:0]       H_LIM     = 11'(H_PIX);
    localparam logic [10:0]       V_LIM     = 11'(V_PIX);

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_W_P1   = 3'd2,
        ST_W_P1B  = 3'd3,
        ST_W_P2   = 3'd4,
        ST_W_P2B  = 3'd5
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [ADDR_W-1:0] clr_cnt_r, clr_cnt_nxt_s;
    logic              clr_pend_r, take_clr_s, snap_ld_s;
    logic              fsync1_r, fsync2_r, fsync3_r, frame_tick_s;
    logic [9:0]        p1_x_r, p1_y_r, p2_x_r, p2_y_r;
    logic              p1_alive_r, p2_alive_r;
    logic              we_s, done_s;
    logic [ADDR_W-1:0] addr_s, p1_addr_s, p2_addr_s;
    logic [15:0]       data_s;
    logic              p1_ok_s, p2_ok_s;
`ifdef TRAIL_DOUBLE_EN
    logic              p1_low_ok_s, p2_low_ok_s;
`endif

    function automatic logic [15:0] pair_word(input logic [3:0] color);
        return {8'h00, color, color};
    endfunction

    // Row offset is a constant multiply (shift-add for 640-wide frames).
    function automatic logic [ADDR_W-1:0] word_addr(input logic [9:0] x, input logic [9:0] y);
        return ADDR_W'(x[9:1]) + ADDR_W'(y) * ROW_PITCH;
    endfunction

    function automatic logic on_screen(input logic [9:0] x, input logic [9:0] y);
        return ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
    endfunction

    assign frame_tick_s = fsync2_r & ~fsync3_r;
    assign p1_ok_s      = p1_alive_r && on_screen(p1_x_r, p1_y_r);
    assign p2_ok_s      = p2_alive_r && on_screen(p2_x_r, p2_y_r);
    assign p1_addr_s    = word_addr(p1_x_r, p1_y_r);
    assign p2_addr_s    = word_addr(p2_x_r, p2_y_r);
`ifdef TRAIL_DOUBLE_EN
    assign p1_low_ok_s  = ({1'b0, p1_y_r} + 11'd1) < V_LIM;
    assign p2_low_ok_s  = ({1'b0, p2_y_r} + 11'd1) < V_LIM;
`endif

    // Synchronise the frame strobe and keep one extra stage for edge detection
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fsync1_r <= 1'b0;
            fsync2_r <= 1'b0;
            fsync3_r <= 1'b0;
        end else begin
            fsync1_r <= frame_clk;
            fsync2_r <= fsync1_r;
            fsync3_r <= fsync2_r;
        end
    end

    // State, clear counter and pending-clear flag
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r    <= ST_CLEAR;
            clr_cnt_r  <= {ADDR_W{1'b0}};
            clr_pend_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            if (take_clr_s) begin
                clr_pend_r <= 1'b0;
            end else if (clear_req && (state_r != ST_CLEAR)) begin
                clr_pend_r <= 1'b1;
            end
        end
    end

    // Snapshot of bike inputs taken when a frame sequence starts
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            p1_x_r <= 10'd0; p1_y_r <= 10'd0; p1_alive_r <= 1'b0;
            p2_x_r <= 10'd0; p2_y_r <= 10'd0; p2_alive_r <= 1'b0;
        end else if (snap_ld_s) begin
            p1_x_r <= p1_x; p1_y_r <= p1_y; p1_alive_r <= p1_alive;
            p2_x_r <= p2_x; p2_y_r <= p2_y; p2_alive_r <= p2_alive;
        end
    end

    // Next-state and write-port decode; address/data hold when no write is issued
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        take_clr_s    = 1'b0;
        snap_ld_s     = 1'b0;
        we_s          = 1'b0;
        done_s        = 1'b0;
        addr_s        = write_address;
        data_s        = Data_In;
        case (state_r)
            ST_CLEAR: begin
                we_s   = 1'b1;
                addr_s = clr_cnt_r;
                data_s = pair_word(BG_COLOR);
                if (clr_cnt_r == LAST_ADDR) begin
                    done_s        = 1'b1;
                    clr_cnt_nxt_s = {ADDR_W{1'b0}};
                    state_nxt_s   = ST_IDLE;
                end else begin
                    clr_cnt_nxt_s = clr_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            ST_IDLE: begin
                if (clr_pend_r || clear_req) begin
                    take_clr_s    = 1'b1;
                    clr_cnt_nxt_s = {ADDR_W{1'b0}};
                    state_nxt_s   = ST_CLEAR;
                end else if (frame_tick_s) begin
                    snap_ld_s   = 1'b1;
                    state_nxt_s = ST_W_P1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_W_P1: begin
                if (p1_ok_s) begin
                    we_s   = 1'b1;
                    addr_s = p1_addr_s;
                    data_s = pair_word(P1_COLOR);
                end else begin
                    we_s = 1'b0;
                end
`ifdef TRAIL_DOUBLE_EN
                state_nxt_s = ST_W_P1B;
`else
                state_nxt_s = ST_W_P2;
`endif
            end
`ifdef TRAIL_DOUBLE_EN
            ST_W_P1B: begin
                if (p1_ok_s && p1_low_ok_s) begin
                    we_s   = 1'b1;
                    addr_s = p1_addr_s + ROW_PITCH;
                    data_s = pair_word(P1_COLOR);
                end else begin
                    we_s = 1'b0;
                end
                state_nxt_s = ST_W_P2;
            end
`endif
            ST_W_P2: begin
                if (p2_ok_s) begin
                    we_s   = 1'b1;
                    addr_s = p2_addr_s;
                    data_s = pair_word(P2_COLOR);
                end else begin
                    we_s = 1'b0;
                end
`ifdef TRAIL_DOUBLE_EN
                state_nxt_s = ST_W_P2B;
`else
                state_nxt_s = ST_IDLE;
`endif
            end
`ifdef TRAIL_DOUBLE_EN
            ST_W_P2B: begin
                if (p2_ok_s && p2_low_ok_s) begin
                    we_s   = 1'b1;
                    addr_s = p2_addr_s + ROW_PITCH;
                    data_s = pair_word(P2_COLOR);
                end else begin
                    we_s = 1'b0;
                end
                state_nxt_s = ST_IDLE;
            end
`endif
            default: begin
                clr_cnt_nxt_s = {ADDR_W{1'b0}};
                state_nxt_s   = ST_CLEAR;
            end
        endcase
    end

    // Registered outputs; busy tracks the state whose write is currently on the port
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            WE            <= 1'b0;
            write_address <= {ADDR_W{1'b0}};
            Data_In       <= 16'h0000;
            clear_done    <= 1'b0;
            busy          <= 1'b1;
        end else begin
            WE            <= we_s;
            write_address <= addr_s;
            Data_In       <= data_s;
            clear_done    <= done_s;
            busy          <= (state_r != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_trail_writer.sv
// Scoreboard bench for trail_writer: expected writes are queued as stimulus is driven
// and popped by a write monitor. Reduced V_PIX keeps full clears short.
`timescale 1ns/1ps
module tb_trail_writer;
    localparam int H_PIX = 640;
    localparam int V_PIX = 52;
    localparam int ROW_W = H_PIX / 2;
    localparam int WORDS = ROW_W * V_PIX;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        clear_req = 1'b0;
    logic [9:0]  p1_x = 10'd0, p1_y = 10'd0, p2_x = 10'd0, p2_y = 10'd0;
    logic        p1_alive = 1'b0, p2_alive = 1'b0;
    logic [18:0] write_address;
    logic [15:0] Data_In;
    logic        WE, busy, clear_done;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
        logic        done;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   n_writes = 0;
    int   n_done = 0;

    trail_writer #(.H_PIX(H_PIX), .V_PIX(V_PIX), .ADDR_W(19)) dut (
        .Clk(clk), .Reset(reset_n), .frame_clk(frame_clk), .clear_req(clear_req),
        .p1_x(p1_x), .p1_y(p1_y), .p1_alive(p1_alive),
        .p2_x(p2_x), .p2_y(p2_y), .p2_alive(p2_alive),
        .write_address(write_address), .Data_In(Data_In), .WE(WE),
        .busy(busy), .clear_done(clear_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_write(input int addr, input logic [15:0] data, input logic done);
        exp_t e;
        e.addr = 32'(addr);
        e.data = data;
        e.done = done;
        sb.push_back(e);
    endtask

    task automatic push_clear();
        for (int i = 0; i < WORDS; i++) push_write(i, 16'h0000, (i == WORDS - 1));
    endtask

    task automatic push_bike(input int x, input int y, input logic alive, input logic [3:0] color);
        if (alive && x < H_PIX && y < V_PIX) begin
            push_write(y * ROW_W + x / 2, {8'h00, color, color}, 1'b0);
`ifdef TRAIL_DOUBLE_EN
            if (y + 1 < V_PIX) push_write((y + 1) * ROW_W + x / 2, {8'h00, color, color}, 1'b0);
`endif
        end
    endtask

    task automatic set_bikes(input int x1, input int y1, input logic a1,
                             input int x2, input int y2, input logic a2);
        p1_x = 10'(x1); p1_y = 10'(y1); p1_alive = a1;
        p2_x = 10'(x2); p2_y = 10'(y2); p2_alive = a2;
        push_bike(x1, y1, a1, 4'h1);
        push_bike(x2, y2, a2, 4'h2);
    endtask

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic frame_edge(input string tag);
        cycles(1);
        frame_clk = 1'b1;
        cycles(4);
        frame_clk = 1'b0;
        cycles(8);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_we(input string tag, input int budget);
        int i;
        i = 0;
        while (!WE && i < budget) begin
            cycles(1);
            i++;
        end
        check({tag, "_we_seen"}, {31'd0, WE}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start, i;
        start = n_done;
        i = 0;
        while (n_done == start && i < budget) begin
            cycles(1);
            i++;
        end
        check({tag, "_done_pulses"}, 32'(n_done - start), 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd1);
        cycles(1);
        check({tag, "_busy_after_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_done_one_clk"}, {31'd0, clear_done}, 32'd0);
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    // Write monitor: every WE cycle must match the head of the scoreboard
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n) begin
            if (WE) begin
                n_writes++;
                if (sb.size() == 0) begin
                    check("write_unexpected", {31'd0, WE}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(write_address), e.addr);
                    check("wr_data", 32'(Data_In), 32'(e.data));
                    check("wr_done", {31'd0, clear_done}, {31'd0, e.done});
                end
            end else begin
                check("done_without_we", {31'd0, clear_done}, 32'd0);
            end
            if (clear_done) n_done++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: run still active at %0t, expected finish", $time);
        $fatal(1);
    end

    initial begin
        int wr_before;
        int i;

        #12;
        check("rst_we", {31'd0, WE}, 32'd0);
        check("rst_addr", 32'(write_address), 32'd0);
        check("rst_data", 32'(Data_In), 32'd0);
        check("rst_done", {31'd0, clear_done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd1);

        // initial clear after reset release
        push_clear();
        cycles(1);
        reset_n = 1'b1;
        wait_done("clr0", WORDS + 100);
        check("clr0_count", 32'(n_writes), 32'(WORDS));

        // p1 on screen, p2 at x=H_PIX; p2 inputs changed mid-sequence are ignored
        set_bikes(101, 50, 1'b1, 640, 10, 1'b1);
        cycles(1);
        frame_clk = 1'b1;
        wait_we("t2", 20);
        p2_x = 10'd100; p2_y = 10'd20; p2_alive = 1'b1;
        cycles(3);
        frame_clk = 1'b0;
        cycles(8);
        check("t2_sb_empty", 32'(sb.size()), 32'd0);

        set_bikes(5, 5, 1'b0, 0, V_PIX - 1, 1'b1);
        frame_edge("t3");
        set_bikes(639, V_PIX - 1, 1'b1, 0, V_PIX, 1'b1);
        frame_edge("t3b");
        set_bikes(10, 20, 1'b1, 0, 0, 1'b0);
        frame_edge("t6a");
        set_bikes(10, V_PIX - 1, 1'b1, 0, 0, 1'b0);
        frame_edge("t6b");
        wr_before = n_writes;
        set_bikes(10, 20, 1'b0, 30, 30, 1'b0);
        frame_edge("dead");
        check("dead_no_write", 32'(n_writes - wr_before), 32'd0);

        // clear request during the frame sequence; frame edges during the clear are dropped
        set_bikes(200, 10, 1'b1, 300, 40, 1'b1);
        push_clear();
        cycles(1);
        frame_clk = 1'b1;
        wait_we("t4", 20);
        clear_req = 1'b1;
        cycles(1);
        clear_req = 1'b0;
        frame_clk = 1'b0;
        cycles(20);
        for (int k = 0; k < 2; k++) begin
            frame_clk = 1'b1;
            cycles(4);
            frame_clk = 1'b0;
            cycles(4);
        end
        wait_done("t4", WORDS + 100);
        wr_before = n_writes;
        cycles(12);
        check("t4_no_late_write", 32'(n_writes - wr_before), 32'd0);

        // reset in IDLE, then again in the middle of the clear
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy", {31'd0, busy}, 32'd1);
        push_clear();
        cycles(1);
        reset_n = 1'b1;
        i = 0;
        while (!(WE && write_address == 19'd1000) && i < 3000) begin
            cycles(1);
            i++;
        end
        check("t5_reach_1000", 32'(write_address), 32'd1000);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_we", {31'd0, WE}, 32'd0);
        check("t5_async_addr", 32'(write_address), 32'd0);
        sb.delete();
        cycles(3);
        push_clear();
        reset_n = 1'b1;
        wait_done("t5", WORDS + 100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
